// File: rtl/ha_bist_pkg.sv
// ---------------------------------------------------------------------------
// ha_bist_pkg
// Shared types and helpers for the half-adder BIST sequencer.
//   state_e      : sequencer FSM states
//   NUM_VECTORS  : number of distinct half-adder input vectors
//   LAST_VEC     : index of the final vector in a sweep
//   ha_expected(): golden {c,s} for a 2-bit vector index (x = i[0], y = i[1])
// ---------------------------------------------------------------------------
package ha_bist_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        DONE
    } state_e;

    localparam int         NUM_VECTORS = 4;
    localparam logic [1:0] LAST_VEC    = 2'(NUM_VECTORS - 1);

    function automatic logic [1:0] ha_expected(input logic [1:0] vec);
        return {vec[1] & vec[0], vec[1] ^ vec[0]};
    endfunction

endpackage

// File: rtl/ha_bist_sequencer_if.sv
// ---------------------------------------------------------------------------
// ha_bist_sequencer_if
// Stimulus/response bus between the BIST sequencer and the half adder.
//   x_out, y_out : half-adder operand inputs (driven by the sequencer)
//   s_in, c_in   : half-adder sum/carry responses (driven by the half adder)
// Modports:
//   master : the sequencer side
//   slave  : the half-adder side
// ---------------------------------------------------------------------------
interface ha_bist_sequencer_if;

    logic x_out;
    logic y_out;
    logic s_in;
    logic c_in;

    modport master (output x_out, output y_out, input  s_in, input  c_in);
    modport slave  (input  x_out, input  y_out, output s_in, output c_in);

endinterface

// File: rtl/ha_bist_checker.sv
// ---------------------------------------------------------------------------
// ha_bist_checker
// Compares a sampled half-adder response with the golden value and
// accumulates the run results.
//   clk, rst        : clock, asynchronous active-high reset
//   clear_i         : wipe err_count/fail_vec at the start of a run
//   en_i            : this cycle is a sample cycle
//   vec_i           : vector index currently applied
//   s_i, c_i        : half-adder response
//   err_count_o     : saturating mismatch count
//   fail_vec_o      : sticky per-vector failure mask
//   err_zero_next_o : err_count will be zero after this edge
// ---------------------------------------------------------------------------
module ha_bist_checker
    import ha_bist_pkg::*;
#(
    parameter int ERR_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear_i,
    input  logic                   en_i,
    input  logic [1:0]             vec_i,
    input  logic                   s_i,
    input  logic                   c_i,
    output logic [ERR_W-1:0]       err_count_o,
    output logic [NUM_VECTORS-1:0] fail_vec_o,
    output logic                   err_zero_next_o
);

    logic [ERR_W-1:0]       err_q, err_d;
    logic [NUM_VECTORS-1:0] fail_q, fail_d;
    logic                   mismatch;

    assign mismatch = en_i && ({c_i, s_i} != ha_expected(vec_i));

    always_comb begin
        // NOTE: defaults first so every path assigns; otherwise a latch is inferred.
        err_d  = err_q;
        fail_d = fail_q;
        if (clear_i) begin
            err_d  = '0;
            fail_d = '0;
        end else if (mismatch) begin
            // The fail bit is set even when the counter is already saturated.
            fail_d[vec_i] = 1'b1;
            if (err_q != '1) begin
                err_d = err_q + ERR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            err_q  <= '0;
            fail_q <= '0;
        end else begin
            err_q  <= err_d;
            fail_q <= fail_d;
        end
    end

    assign err_count_o     = err_q;
    assign fail_vec_o      = fail_q;
    assign err_zero_next_o = (err_d == '0);

endmodule

// File: rtl/ha_bist_sequencer.sv
// ---------------------------------------------------------------------------
// ha_bist_sequencer
// On a start request, sweeps the four half-adder input vectors N_PASSES
// times, holding each vector SETTLE_CYCLES cycles before a one-cycle sample,
// and reports a saturating error count, a sticky fail mask and a pass flag.
//   clk, rst   : clock, asynchronous active-high reset
//   start      : run request, honoured only in IDLE
//   ha         : half-adder stimulus/response bus (master side)
//   busy       : run in progress
//   done       : one-cycle pulse at the end of a run
//   pass       : last completed run had zero errors
//   err_count  : saturating mismatch count of the last run
//   fail_vec   : bit i set if vector i ever mismatched
// ---------------------------------------------------------------------------
module ha_bist_sequencer
    import ha_bist_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int N_PASSES      = 1,
    parameter int ERR_W         = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    ha_bist_sequencer_if.master       ha,
    output logic                      busy,
    output logic                      done,
    output logic                      pass,
    output logic [ERR_W-1:0]          err_count,
    output logic [NUM_VECTORS-1:0]    fail_vec
);

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int PW = (N_PASSES > 1) ? $clog2(N_PASSES) : 1;

    // With no settle time each vector goes straight to its sample cycle.
    localparam state_e FIRST_STATE = (SETTLE_CYCLES == 0) ? SAMPLE : DRIVE;

    state_e          state_q;
    logic [1:0]      vec_q;
    logic [1:0]      vec_inc_d;
    logic [PW-1:0]   pass_idx_q;
    logic [SW-1:0]   settle_q;
    logic            x_q, y_q;
    logic            busy_q, done_q, pass_q;
    logic            err_zero_next;

    assign vec_inc_d = vec_q + 2'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            vec_q      <= '0;
            pass_idx_q <= '0;
            settle_q   <= '0;
            x_q        <= 1'b0;
            y_q        <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        vec_q      <= '0;
                        pass_idx_q <= '0;
                        settle_q   <= '0;
                        x_q        <= 1'b0;
                        y_q        <= 1'b0;
                        busy_q     <= 1'b1;
                        pass_q     <= 1'b0;
                        state_q    <= FIRST_STATE;
                    end
                end
                DRIVE: begin
                    if (settle_q == SW'(SETTLE_CYCLES - 1)) begin
                        settle_q <= '0;
                        state_q  <= SAMPLE;
                    end else begin
                        settle_q <= settle_q + SW'(1);
                    end
                end
                SAMPLE: begin
                    if (vec_q != LAST_VEC) begin
                        vec_q   <= vec_inc_d;
                        x_q     <= vec_inc_d[0];
                        y_q     <= vec_inc_d[1];
                        state_q <= FIRST_STATE;
                    end else if (pass_idx_q != PW'(N_PASSES - 1)) begin
                        vec_q      <= '0;
                        pass_idx_q <= pass_idx_q + PW'(1);
                        x_q        <= 1'b0;
                        y_q        <= 1'b0;
                        state_q    <= FIRST_STATE;
                    end else begin
                        // Final sample: the checker's next count decides pass,
                        // so pass is valid in the same cycle as done.
                        x_q     <= 1'b0;
                        y_q     <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= err_zero_next;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    ha_bist_checker #(
        .ERR_W (ERR_W)
    ) u_checker (
        .clk             (clk),
        .rst             (rst),
        .clear_i         ((state_q == IDLE) && start),
        .en_i            (state_q == SAMPLE),
        .vec_i           (vec_q),
        .s_i             (ha.s_in),
        .c_i             (ha.c_in),
        .err_count_o     (err_count),
        .fail_vec_o      (fail_vec),
        .err_zero_next_o (err_zero_next)
    );

    assign ha.x_out = x_q;
    assign ha.y_out = y_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign pass     = pass_q;

endmodule

// File: tb/tb_ha_bist_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ha_bist_sequencer
// Four sequencer instances with different parameter sets, each driving a
// behavioural half adder with a selectable fault. Expected run results are
// computed from the half-adder truth table when a run starts and queued; a
// monitor per instance checks the vector trace and pops the queue on done.
//   inst 0: SETTLE=2 N=1 ERR_W=4
//   inst 1: SETTLE=2 N=2 ERR_W=4
//   inst 2: SETTLE=2 N=2 ERR_W=2
//   inst 3: SETTLE=0 N=1 ERR_W=4
// Fault modes: 0 golden, 1 c stuck-0, 2 s stuck-1, 3 s inverted,
//              4 c inverted, 5 random per-vector flips
// ---------------------------------------------------------------------------
module tb_ha_bist_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst   [4];
    logic       start [4];
    logic       busy  [4];
    logic       done  [4];
    logic       pass  [4];
    logic [3:0] err   [4];
    logic [3:0] fail  [4];
    logic [1:0] err2;
    logic       x_o   [4];
    logic       y_o   [4];

    int         fault [4];
    logic [7:0] fmask [4];
    int         k_cyc [4];
    bit         active[4];
    int         cyc = 0;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int         err;
        logic [3:0] fail;
        logic       pass;
        int         len;
    } exp_t;

    exp_t sb_q[4][$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int s_of(input int g);
        return (g == 3) ? 0 : 2;
    endfunction

    function automatic int n_of(input int g);
        return (g == 1 || g == 2) ? 2 : 1;
    endfunction

    function automatic int e_of(input int g);
        return (g == 2) ? 2 : 4;
    endfunction

    // Half-adder behaviour from plain arithmetic, with an optional fault.
    function automatic logic [1:0] ha_resp(input int mode, input logic [7:0] mask, input int v);
        int x, y, sum;
        logic s, c;
        logic [1:0] r;
        x   = v % 2;
        y   = v / 2;
        sum = x + y;
        s   = ((sum % 2) == 1);
        c   = ((sum / 2) == 1);
        case (mode)
            1: c = 1'b0;
            2: s = 1'b1;
            3: s = !s;
            4: c = !c;
            default: ;
        endcase
        r = {c, s};
        if (mode == 5) r = r ^ mask[2*v +: 2];
        return r;
    endfunction

    ha_bist_sequencer_if hi[4] ();

    ha_bist_sequencer #(.SETTLE_CYCLES(2), .N_PASSES(1), .ERR_W(4)) u_dut0 (
        .clk(clk), .rst(rst[0]), .start(start[0]), .ha(hi[0]), .busy(busy[0]),
        .done(done[0]), .pass(pass[0]), .err_count(err[0]), .fail_vec(fail[0]));
    ha_bist_sequencer #(.SETTLE_CYCLES(2), .N_PASSES(2), .ERR_W(4)) u_dut1 (
        .clk(clk), .rst(rst[1]), .start(start[1]), .ha(hi[1]), .busy(busy[1]),
        .done(done[1]), .pass(pass[1]), .err_count(err[1]), .fail_vec(fail[1]));
    ha_bist_sequencer #(.SETTLE_CYCLES(2), .N_PASSES(2), .ERR_W(2)) u_dut2 (
        .clk(clk), .rst(rst[2]), .start(start[2]), .ha(hi[2]), .busy(busy[2]),
        .done(done[2]), .pass(pass[2]), .err_count(err2), .fail_vec(fail[2]));
    ha_bist_sequencer #(.SETTLE_CYCLES(0), .N_PASSES(1), .ERR_W(4)) u_dut3 (
        .clk(clk), .rst(rst[3]), .start(start[3]), .ha(hi[3]), .busy(busy[3]),
        .done(done[3]), .pass(pass[3]), .err_count(err[3]), .fail_vec(fail[3]));

    assign err[2] = {2'b00, err2};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    for (genvar g = 0; g < 4; g++) begin : g_inst
        assign x_o[g] = hi[g].x_out;
        assign y_o[g] = hi[g].y_out;
        assign {hi[g].c_in, hi[g].s_in} = ha_resp(fault[g], fmask[g], int'({y_o[g], x_o[g]}));

        // Monitor: vector trace while running, scoreboard pop on done.
        initial begin
            int m, len;
            logic [1:0] ev;
            exp_t e;
            forever begin
                @(negedge clk);
                if (!rst[g]) begin
                    m   = cyc - k_cyc[g];
                    len = 4 * n_of(g) * (s_of(g) + 1);
                    if (done[g]) begin
                        if (sb_q[g].size() == 0) begin
                            n_checks++;
                            n_fail++;
                            $display("FAIL spurious_done[%0d]: got done=1, expected no pending run", g);
                        end else begin
                            e = sb_q[g].pop_front();
                            check($sformatf("done_latency[%0d]", g), m, e.len);
                            check($sformatf("err_count[%0d]", g), err[g], e.err);
                            check($sformatf("fail_vec[%0d]", g), fail[g], e.fail);
                            check($sformatf("pass[%0d]", g), pass[g], e.pass);
                            check($sformatf("busy_at_done[%0d]", g), busy[g], 0);
                            check($sformatf("xy_at_done[%0d]", g), {y_o[g], x_o[g]}, 0);
                            active[g] = 1'b0;
                        end
                    end else if (active[g] && m < len) begin
                        ev = 2'((m / (s_of(g) + 1)) % 4);
                        check($sformatf("x_trace[%0d]", g), x_o[g], ev[0]);
                        check($sformatf("y_trace[%0d]", g), y_o[g], ev[1]);
                        check($sformatf("busy_run[%0d]", g), busy[g], 1);
                    end else if (active[g]) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL done_missing[%0d]: got done=0 at offset %0d, expected 1", g, m);
                        active[g] = 1'b0;
                        sb_q[g].delete();
                    end else begin
                        check($sformatf("xy_idle[%0d]", g), {y_o[g], x_o[g]}, 0);
                        check($sformatf("busy_idle[%0d]", g), busy[g], 0);
                    end
                end
            end
        end
    end

    task automatic start_run(input int g, input int mode);
        exp_t e;
        int cnt, maxe;
        logic [1:0] r, t;
        fault[g] = mode;
        fmask[g] = 8'($urandom);
        cnt    = 0;
        e.fail = '0;
        for (int p = 0; p < n_of(g); p++) begin
            for (int v = 0; v < 4; v++) begin
                r = ha_resp(mode, fmask[g], v);
                t = ha_resp(0, 8'h00, v);
                if (r != t) begin
                    cnt++;
                    e.fail[v] = 1'b1;
                end
            end
        end
        maxe   = (1 << e_of(g)) - 1;
        e.err  = (cnt > maxe) ? maxe : cnt;
        e.pass = (cnt == 0);
        e.len  = 4 * n_of(g) * (s_of(g) + 1);
        @(negedge clk);
        #1;
        start[g] = 1'b1;
        sb_q[g].push_back(e);
        @(posedge clk);
        #1;
        k_cyc[g]  = cyc;
        active[g] = 1'b1;
        check($sformatf("start_clr_err[%0d]", g), err[g], 0);
        check($sformatf("start_clr_fail[%0d]", g), fail[g], 0);
        check($sformatf("start_clr_pass[%0d]", g), pass[g], 0);
        check($sformatf("start_busy[%0d]", g), busy[g], 1);
        @(negedge clk);
        #1;
        start[g] = 1'b0;
    endtask

    task automatic wait_idle(input int g);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            #2;
            if (!active[g]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL run_timeout[%0d]: got no done within 500 cycles, expected done", g);
            active[g] = 1'b0;
            sb_q[g].delete();
        end
    endtask

    initial begin
        int g, mode;
        for (int i = 0; i < 4; i++) begin
            rst[i]    = 1'b1;
            start[i]  = 1'b0;
            fault[i]  = 0;
            fmask[i]  = '0;
            k_cyc[i]  = 0;
            active[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rst_busy[%0d]", i), busy[i], 0);
            check($sformatf("rst_done[%0d]", i), done[i], 0);
            check($sformatf("rst_pass[%0d]", i), pass[i], 0);
            check($sformatf("rst_err[%0d]", i), err[i], 0);
            check($sformatf("rst_fail[%0d]", i), fail[i], 0);
            check($sformatf("rst_xy[%0d]", i), {y_o[i], x_o[i]}, 0);
        end
        @(negedge clk);
        #1;
        for (int i = 0; i < 4; i++) rst[i] = 1'b0;

        // Golden run, then c stuck-at-0.
        start_run(0, 0);
        wait_idle(0);
        start_run(0, 1);
        wait_idle(0);

        // Re-pulsed start mid-run is ignored; this run also clears the
        // previous failing results.
        start_run(0, 0);
        while (cyc != k_cyc[0] + 4) @(negedge clk);
        #1;
        start[0] = 1'b1;
        @(negedge clk);
        #1;
        start[0] = 1'b0;
        wait_idle(0);

        // Reset mid-run at edge k+6: immediate clear, no done.
        start_run(0, 2);
        while (cyc != k_cyc[0] + 6) begin
            @(posedge clk);
            #1;
        end
        rst[0]    = 1'b1;
        active[0] = 1'b0;
        sb_q[0].delete();
        #1;
        check("abort_busy", busy[0], 0);
        check("abort_done", done[0], 0);
        check("abort_xy", {y_o[0], x_o[0]}, 0);
        check("abort_err", err[0], 0);
        check("abort_fail", fail[0], 0);
        @(negedge clk);
        #1;
        rst[0] = 1'b0;
        repeat (20) @(negedge clk);
        start_run(0, 0);
        wait_idle(0);

        // s stuck-at-1 with two passes; saturating count with inverted s.
        start_run(1, 2);
        wait_idle(1);
        start_run(2, 3);
        wait_idle(2);

        // Zero settle time.
        start_run(3, 0);
        wait_idle(3);

        // Randomized runs across all instances and fault modes.
        for (int r = 0; r < 24; r++) begin
            g    = int'($urandom_range(3, 0));
            mode = int'($urandom_range(5, 0));
            repeat ($urandom_range(3, 0)) @(negedge clk);
            start_run(g, mode);
            wait_idle(g);
        end

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ha_bist_sequencer.md
Name: ha_bist_sequencer

Overview:
- On-chip initiator/checker for the half-adder datapath: drives the x/y inputs and samples the S/C responses.
- On a start pulse, sweeps all four input vectors for N_PASSES passes and compares each response against s = x^y, c = x&y.
- Accumulates a saturating error count and a sticky per-vector fail mask, then pulses done.
- Lets silicon self-check the half adder through spare ui_in/uo_out pins, with no external tester.

Parameters:
- SETTLE_CYCLES, 2, cycles a vector is held before the sample cycle (0 allowed).
- N_PASSES, 1, number of full 4-vector sweeps per run (>=1).
- ERR_W, 4, width of err_count; the counter saturates.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  run request; honoured only in IDLE.
- x_out  output  1  registered half-adder input x.
- y_out  output  1  registered half-adder input y.
- s_in  input  1  half-adder sum response.
- c_in  input  1  half-adder carry response.
- busy  output  1  high while a run is in progress.
- done  output  1  one-cycle pulse at end of run.
- pass  output  1  1 when the last completed run had zero errors.
- err_count  output  ERR_W  saturating mismatch count of the last run.
- fail_vec  output  4  sticky mask; bit i set if vector i ever mismatched.

Behaviour:
- Reset values: every output 0; state IDLE; vector index 0; pass index 0; settle counter 0.
- rst asserted at any time, including mid-run:
  - Immediate return to IDLE with all outputs 0.
  - No done pulse for the aborted run.
- Vector index i (2 bits) maps to x = i[0], y = i[1]. Order is i = 0,1,2,3, so (x,y) = (0,0),(1,0),(0,1),(1,1).
- State IDLE:
  - busy=0, x_out=y_out=0; pass, err_count and fail_vec hold their last values.
  - Edge with start=1 performs all of the following:
    - Clear err_count and fail_vec; clear pass.
    - Load vector 0 onto x_out/y_out and set busy=1.
    - Go to DRIVE, or to SAMPLE if SETTLE_CYCLES=0.
- State DRIVE:
  - Hold x/y for exactly SETTLE_CYCLES cycles, counting with the settle counter, then go to SAMPLE.
- State SAMPLE (one cycle): at its closing edge, compare s_in/c_in against the expected values for the current vector.
  - On mismatch: err_count += 1, saturating at 2^ERR_W-1, and set fail_vec[i].
  - i<3: i+1, load the new x/y, go to DRIVE (or SAMPLE if SETTLE_CYCLES=0).
  - i=3, passes remaining: i=0, increment the pass index, continue as above.
  - i=3, last pass: go to DONE; x_out/y_out go to 0.
- A sample cycle that saturates err_count still sets fail_vec.
- State DONE (one cycle):
  - done=1, busy=0.
  - pass = (err_count==0 after the final sample).
  - Next state IDLE.
- Run timing:
  - Each vector occupies SETTLE_CYCLES+1 cycles.
  - With the start edge at k, done is high in the cycle following edge k + 4·N_PASSES·(SETTLE_CYCLES+1).
- start is ignored in DRIVE, SAMPLE and DONE. It is not queued.
- start high in the cycle after DONE (IDLE) begins a new run normally.
- s_in/c_in are sampled only at SAMPLE closing edges; their value at any other time is don't-care.

Decomposition:
- Package ha_bist_pkg holds:
  - State enum IDLE/DRIVE/SAMPLE/DONE.
  - Constant NUM_VECTORS=4.
  - A function returning expected {c,s} for a 2-bit vector index.
- One sub-module, ha_bist_checker, holds compare, the saturating err_count and fail_vec accumulation. It has enable, vector index and clear inputs.
- The FSM, counters and x/y registers stay in the top.

Test Plan:
- Golden DUT model, SETTLE=2, N=1, start at edge k:
  - (x,y) steps 00,10,01,11, 3 cycles each.
  - done pulses in the cycle after edge k+12; pass=1, err_count=0, fail_vec=0000.
- c stuck-at-0 fault, SETTLE=2, N=1 -> err_count=1, fail_vec=1000, pass=0.
- s stuck-at-1 fault, N=2 -> vectors 0 and 3 fail each pass; err_count=4, fail_vec=1001, pass=0.
- start re-pulsed at edge k+5 during the run -> ignored; done still in the cycle after k+12.
  - A second start after done clears the results.
  - With the golden DUT this gives pass=1.
- rst pulsed at edge k+6 -> busy, x_out, y_out, err_count and fail_vec at 0 within the same cycle; no done.
  - A later start completes a full 12-cycle run.
- ERR_W=2, N=2, inverted-s fault (all 8 samples fail) -> err_count saturates at 3, fail_vec=1111, pass=0.
- SETTLE=0 golden run -> vectors advance every cycle; done in the cycle after edge k+4.
